multiplicador_sequencial: RTL and testbench
===========================================

MULTIPLICADOR_SEQUENCIAL -- requirements
Module: multiplicador_sequencial

Interface
REQ-001 The block SHALL have parameter LARGURA, default 8, giving the operand width; the ALU integration uses 8 only.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, the reset; asynchronous, active-high.
REQ-004 The block SHALL have port START, input, 1, the operation request, sampled only in IDLE.
REQ-005 The block SHALL have port A, input, LARGURA, the unsigned multiplicand.
REQ-006 The block SHALL have port B, input, LARGURA, the unsigned multiplier.
REQ-007 The block SHALL have port Y, output, LARGURA, the low half of the product; it feeds one 8-bit data input of the ALU result-select mux.
REQ-008 The block SHALL have port Y_HI, output, LARGURA, the high half of the product.
REQ-009 The block SHALL have port OVF, output, 1, asserted when Y_HI is nonzero.
REQ-010 The block SHALL have port BUSY, output, 1, high while iterating.
REQ-011 The block SHALL have port DONE, output, 1, a one-cycle completion pulse.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CALC, FIM.
REQ-013 In IDLE with START=1, a rising edge SHALL do all of the following:
- capture A and B into internal registers;
- clear the 2*LARGURA-bit accumulator;
- clear the iteration counter;
- move to CALC.
REQ-014 In IDLE with START=0, the state and all outputs SHALL hold.
REQ-015 Each rising edge in CALC SHALL perform one shift-add iteration:
- if the captured multiplier LSB is 1, add the captured multiplicand into the accumulator upper half, keeping the carry-out;
- shift {carry, accumulator} right by one;
- shift the multiplier right by one;
- increment the counter.
REQ-016 CALC SHALL last exactly LARGURA edges.
REQ-017 On the LARGURA-th CALC edge, the block SHALL load Y, Y_HI and OVF from the final product and move to FIM.
REQ-018 FIM SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 BUSY SHALL be 1 exactly while in CALC; DONE SHALL be 1 exactly while in FIM; BUSY and DONE SHALL never both be 1.
REQ-020 Latency: for START sampled at edge k, DONE SHALL be high between edge k+LARGURA and edge k+LARGURA+1 (k+8 to k+9 at default width).
REQ-021 START in CALC or FIM SHALL be ignored: no restart and no queuing.
REQ-022 START high in the first IDLE cycle after FIM SHALL begin a new operation (back-to-back throughput of LARGURA+2 cycles).
REQ-023 Changes on A and B after the capture edge SHALL NOT affect the result in progress.
REQ-024 Y, Y_HI and OVF SHALL hold the last completed result from completion until the next completion.
REQ-025 Arithmetic SHALL be unsigned, with Y_HI:Y = A*B exact and no truncation.
REQ-026 A zero operand SHALL still take the full LARGURA iterations and yield a zero product with OVF=0.
REQ-027 The next-state and iteration logic SHALL be free of latches; every register SHALL have a defined reset value.

Reset
REQ-028 RST=1 SHALL, immediately and without waiting for CLK, force all of the following:
- state to IDLE;
- Y, Y_HI, OVF, BUSY and DONE to 0;
- the internal operand, accumulator and counter registers to 0.
REQ-029 RST asserted mid-CALC SHALL abort the operation with no DONE pulse and no partial result on Y or Y_HI.
REQ-030 After RST deasserts, the first rising edge with START=1 SHALL start a normal operation.

Verification
REQ-031 The bench SHALL cover power-on reset: RST pulse with no clock edge -> Y=0x00, Y_HI=0x00, OVF=0, BUSY=0, DONE=0.
REQ-032 The bench SHALL cover a basic product: A=13, B=11, START for one cycle -> BUSY high for 8 cycles, then DONE for 1 cycle, Y=0x8F, Y_HI=0x00, OVF=0.
REQ-033 The bench SHALL cover the maximum product: A=255, B=255 -> Y=0x01, Y_HI=0xFE, OVF=1; also A=0, B=200 -> Y=0x00, OVF=0 after 8 cycles.
REQ-034 The bench SHALL cover operand capture: A=16, B=16 started, then A and B changed to 0xFF and START pulsed during CALC -> single DONE, Y=0x00, Y_HI=0x01, OVF=1.
REQ-035 The bench SHALL cover back-to-back operations: START held high continuously with A=2, B=3 -> DONE pulses every 10 cycles, Y=0x06 each time.
REQ-036 The bench SHALL cover mid-operation reset: RST asserted at the 4th CALC cycle of A=200, B=100 -> outputs 0 at once, no DONE; a new A=3, B=5 then gives Y=0x0F.

Source files
------------

// File: rtl/multiplicador_sequencial.sv
// multiplicador_sequencial: unsigned shift-add multiplier, one partial product per clock.
module multiplicador_sequencial #(
  parameter int LARGURA = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic [LARGURA-1:0] Y,
  output logic [LARGURA-1:0] Y_HI,
  output logic               OVF,
  output logic               BUSY,
  output logic               DONE
);
  localparam int CW = $clog2(LARGURA) + 1;
  localparam logic [CW-1:0] LAST = CW'(LARGURA - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
  state_t r_state, w_next;
  logic [LARGURA-1:0]   r_a, r_b, r_y, r_y_hi;
  logic [2*LARGURA-1:0] r_acc, w_acc_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf, w_last, w_unused_lsb;
  logic [LARGURA:0]     w_sum;
  // Carry-out of the upper-half add becomes the new MSB after the right shift.
  assign w_sum        = {1'b0, r_acc[2*LARGURA-1:LARGURA]} + {1'b0, (r_b[0] ? r_a : '0)};
  assign w_acc_next   = {w_sum, r_acc[LARGURA-1:1]};
  assign w_unused_lsb = r_acc[0];
  assign w_last       = (r_cnt == LAST);
  assign Y            = r_y;
  assign Y_HI         = r_y_hi;
  assign OVF          = r_ovf;
  always_comb begin
    w_next = IDLE;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    w_next = (r_state == IDLE) ? (START ? CALC : IDLE) :
             (r_state == CALC) ? (w_last ? FIM : CALC) : IDLE;
    BUSY   = (r_state == CALC);
    DONE   = (r_state == FIM);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_y_hi <= '0;
      r_ovf  <= 1'b0;
    end else if (r_state == IDLE && START) begin
      r_a   <= A;
      r_b   <= B;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_next;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_y    <= w_acc_next[LARGURA-1:0];
        r_y_hi <= w_acc_next[2*LARGURA-1:LARGURA];
        r_ovf  <= |w_acc_next[2*LARGURA-1:LARGURA];
      end
    end
  end
endmodule

// File: tb/tb_multiplicador_sequencial.sv
// tb_multiplicador_sequencial: directed and random checks against an arithmetic product model.
module tb_multiplicador_sequencial;
  logic       CLK, RST, START, OVF, BUSY, DONE;
  logic [7:0] A, B, Y, Y_HI;
  int checks = 0;
  int passed = 0;

  multiplicador_sequencial #(.LARGURA(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .Y(Y), .Y_HI(Y_HI), .OVF(OVF), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    int busy_n, n;
    p = 16'(a) * 16'(b);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    busy_n = 0;
    n = 0;
    while (!DONE && n < 20) begin
      @(negedge CLK);
      if (BUSY) busy_n++;
      n++;
    end
    chk("done", {31'b0, DONE}, 1);
    chk("latency", n, 9);
    chk("busy_cycles", busy_n, 8);
    chk("busy_done_excl", {31'b0, BUSY}, 0);
    chk("y", {24'b0, Y}, {24'b0, p[7:0]});
    chk("y_hi", {24'b0, Y_HI}, {24'b0, p[15:8]});
    chk("ovf", {31'b0, OVF}, {31'b0, (p[15:8] != 0)});
    @(negedge CLK);
    chk("done_pulse", {31'b0, DONE}, 0);
    chk("y_hold", {Y_HI, Y}, {16'b0, p});
  endtask

  initial begin
    int last, pulses, dn, n;
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
    #2;
    chk("por_y", {24'b0, Y}, 0);
    chk("por_y_hi", {24'b0, Y_HI}, 0);
    chk("por_ovf", {31'b0, OVF}, 0);
    chk("por_busy", {31'b0, BUSY}, 0);
    chk("por_done", {31'b0, DONE}, 0);
    @(negedge CLK);
    RST = 1'b0;
    op(8'd13, 8'd11);
    op(8'd255, 8'd255);
    op(8'd0, 8'd200);
    op(8'd200, 8'd0);
    for (int i = 0; i < 16; i++) op(8'($urandom), 8'($urandom));

    // operands and START disturbed during CALC
    @(negedge CLK);
    A = 8'd16; B = 8'd16; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      A = 8'hFF; B = 8'hFF;
      START = (i >= 1 && i <= 4);
      if (DONE) dn++;
    end
    START = 1'b0;
    chk("cap_single_done", dn, 1);
    chk("cap_y", {24'b0, Y}, 0);
    chk("cap_y_hi", {24'b0, Y_HI}, 1);
    chk("cap_ovf", {31'b0, OVF}, 1);

    // back-to-back with START held high
    @(negedge CLK);
    A = 8'd2; B = 8'd3; START = 1'b1;
    last = -1;
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge CLK);
      if (DONE) begin
        pulses++;
        chk("b2b_y", {24'b0, Y}, 6);
        if (last >= 0) chk("b2b_gap", i - last, 10);
        last = i;
      end
    end
    START = 1'b0;
    chk("b2b_pulses", pulses, 3);
    n = 0;
    while (!DONE && n < 15) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b_drain", {31'b0, DONE}, 1);
    @(negedge CLK);

    // reset in the 4th CALC cycle
    A = 8'd200; B = 8'd100; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_y", {24'b0, Y}, 0);
    chk("rst_y_hi", {24'b0, Y_HI}, 0);
    chk("rst_ovf", {31'b0, OVF}, 0);
    chk("rst_busy", {31'b0, BUSY}, 0);
    chk("rst_done", {31'b0, DONE}, 0);
    @(negedge CLK);
    RST = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    chk("rst_no_done", dn, 0);
    chk("rst_y_stays0", {Y_HI, Y}, 0);
    op(8'd3, 8'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
